// File: rtl/alu_mc.sv
// alu_mc: multi-cycle signed ALU with valid/ready handshakes on both sides.
// MUL/DIV iterate one bit per cycle on operand magnitudes, sharing one 2*WIDTH register.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADD
`define ADD 5'h00
`endif
`ifndef SUB
`define SUB 5'h01
`endif
`ifndef COMP
`define COMP 5'h02
`endif
`ifndef MUL
`define MUL 5'h03
`endif
`ifndef DIV
`define DIV 5'h04
`endif

module alu_mc #(
    parameter int WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             overflow,
    output logic [1:0]       comp_flag,
    output logic             div_zero,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, hi, lo;
    logic [4:0]       op_code;
    logic [CW-1:0]    count;

    logic             neg, iterate, finish;
    logic [WIDTH-1:0] mag_a, mag_b, sum, diff;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, quot;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_c;
    logic             res_ovf, res_dz, res_ill;
    logic [1:0]       res_cmp;

    // One shift-add (MUL) or restoring-subtract (DIV) step; {hi,lo} is product or {remainder,quotient}.
    always_comb begin
        neg       = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        mag_a     = op_a[WIDTH-1] ? -op_a : op_a;
        mag_b     = op_b[WIDTH-1] ? -op_b : op_b;
        sum       = op_a + op_b;
        diff      = op_a - op_b;
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo[WIDTH-1:1]};
        div_shift = {hi, lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b};
        div_hi    = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_lo    = {lo[WIDTH-2:0], ~div_trial[WIDTH]};
        prod      = neg ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
        quot      = neg ? -div_lo : div_lo;
        iterate   = (op_code == `MUL) || ((op_code == `DIV) && (op_b != '0));
        finish    = ((state == EXEC) && !iterate) || ((state == BUSY) && (count == CW'(1)));
    end

    always_comb begin
        res_c   = '0;
        res_ovf = 1'b0;
        res_cmp = 2'b00;
        res_dz  = 1'b0;
        res_ill = 1'b0;
        if (state == BUSY) begin
            if (op_code == `MUL) begin
                res_c   = prod[WIDTH-1:0];
                res_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end else begin
                // Only MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
                res_c   = quot;
                res_ovf = !neg && div_lo[WIDTH-1];
            end
        end else begin
            case (op_code)
                `ADD: begin
                    res_c   = sum;
                    res_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
                end
                `SUB: begin
                    res_c   = diff;
                    res_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
                end
                `COMP: res_cmp = {$signed(op_a) > $signed(op_b), op_a == op_b};
                `MUL: res_c = '0;
                `DIV: begin
                    res_ovf = (op_b == '0);
                    res_dz  = (op_b == '0);
                end
                default: res_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= '0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            c         <= '0;
            overflow  <= 1'b0;
            comp_flag <= 2'b00;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (finish) begin
                state     <= DONE;
                out_valid <= 1'b1;
                c         <= res_c;
                overflow  <= res_ovf;
                comp_flag <= res_cmp;
                div_zero  <= res_dz;
                illegal   <= res_ill;
            end
            case (state)
                IDLE: if (in_valid) begin
                    op_a     <= a;
                    op_b     <= b;
                    op_code  <= opcode;
                    in_ready <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: if (iterate) begin
                    hi    <= '0;
                    lo    <= mag_a;
                    count <= CW'(WIDTH);
                    state <= BUSY;
                end
                BUSY: begin
                    hi    <= (op_code == `MUL) ? mul_hi : div_hi;
                    lo    <= (op_code == `MUL) ? mul_lo : div_lo;
                    count <= count - 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an integer-arithmetic model.
`ifndef ADD
`define ADD 5'h00
`endif
`ifndef SUB
`define SUB 5'h01
`endif
`ifndef COMP
`define COMP 5'h02
`endif
`ifndef MUL
`define MUL 5'h03
`endif
`ifndef DIV
`define DIV 5'h04
`endif

module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [4:0]  opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c;
    logic        overflow;
    logic [1:0]  comp_flag;
    logic        div_zero;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_c;
    logic        exp_ovf, exp_dz, exp_ill;
    logic [1:0]  exp_cmp;
    int          exp_lat;

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .overflow(overflow), .comp_flag(comp_flag), .div_zero(div_zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: plain signed integer arithmetic, range-checked against 16-bit limits.
    task automatic model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        longint sa, sb, r;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        r = 0;
        exp_ovf = 1'b0; exp_cmp = 2'b00; exp_dz = 1'b0; exp_ill = 1'b0; exp_lat = 1;
        case (op)
            `ADD:  r = sa + sb;
            `SUB:  r = sa - sb;
            `COMP: exp_cmp = {sa > sb, sa == sb};
            `MUL:  begin r = sa * sb; exp_lat = 17; end
            `DIV:  if (sb == 0) begin exp_ovf = 1'b1; exp_dz = 1'b1; end
                   else begin r = sa / sb; exp_lat = 17; end
            default: exp_ill = 1'b1;
        endcase
        if (r > 32767 || r < -32768) exp_ovf = 1'b1;
        exp_c = r[15:0];
    endtask

    task automatic issue(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output("issue_ready", {31'b0, in_ready}, 32'd1);
        opcode = op; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); opcode = 5'($urandom);
    endtask

    task automatic wait_and_check(input string tag);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({tag, "_lat"}, lat, exp_lat);
        check_output({tag, "_c"}, {16'b0, c}, {16'b0, exp_c});
        check_output({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
        check_output({tag, "_cmp"}, {30'b0, comp_flag}, {30'b0, exp_cmp});
        check_output({tag, "_dz"}, {31'b0, div_zero}, {31'b0, exp_dz});
        check_output({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("release_ovalid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic apply_stimulus(input string tag, input logic [4:0] op,
                                  input logic [15:0] x, input logic [15:0] y);
        model(op, x, y);
        issue(op, x, y);
        wait_and_check(tag);
        release_result();
    endtask

    initial begin
        logic [4:0]  rop;
        logic [15:0] ra, rb, held_c;
        int          guard;

        #2;
        check_output("rst_c", {16'b0, c}, 32'd0);
        check_output("rst_ovalid", {31'b0, out_valid}, 32'd0);
        check_output("rst_flags", {27'b0, overflow, comp_flag, div_zero, illegal}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_iready", {31'b0, in_ready}, 32'd1);

        apply_stimulus("add_ovf", `ADD, 16'h7FFF, 16'h0001);
        apply_stimulus("sub_ovf", `SUB, 16'h8000, 16'h0001);
        apply_stimulus("sub_zero_min", `SUB, 16'h0000, 16'h8000);
        apply_stimulus("comp_gt", `COMP, 16'd5, 16'hFFFD);
        apply_stimulus("comp_eq", `COMP, 16'hFFFD, 16'hFFFD);
        apply_stimulus("add_clr_cmp", `ADD, 16'd1, 16'd2);
        apply_stimulus("mul", `MUL, 16'd123, 16'hFFD3);
        apply_stimulus("mul_ovf", `MUL, 16'hFED4, 16'd200);
        apply_stimulus("div_neg", `DIV, 16'hFFF9, 16'd2);
        apply_stimulus("div_min", `DIV, 16'h8000, 16'hFFFF);
        apply_stimulus("div_zero", `DIV, 16'd5, 16'd0);
        apply_stimulus("illegal", 5'h1F, 16'h1234, 16'h5678);
        apply_stimulus("add_zero", `ADD, 16'd0, 16'd0);

        // Backpressure: result must hold and a pending request must wait.
        model(`ADD, 16'd100, 16'd23);
        issue(`ADD, 16'd100, 16'd23);
        wait_and_check("bp_first");
        held_c = exp_c;
        model(`SUB, 16'd10, 16'd3);
        @(negedge clk);
        opcode = `SUB; a = 16'd10; b = 16'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("bp_ovalid", {31'b0, out_valid}, 32'd1);
            check_output("bp_c", {16'b0, c}, {16'b0, held_c});
            check_output("bp_iready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("bp_iready_rise", {31'b0, in_ready}, 32'd1);
        check_output("bp_ovalid_drop", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_and_check("bp_second");
        release_result();

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: rop = `ADD;
                1: rop = `SUB;
                2: rop = `COMP;
                3: rop = `MUL;
                4: rop = `DIV;
                5: rop = 5'($urandom_range(5, 31));
                default: rop = ($urandom_range(0, 1) == 0) ? `MUL : `DIV;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = ra;
                3: rb = 16'($urandom_range(1, 255));
                default: rb = 16'($urandom);
            endcase
            apply_stimulus("rand", rop, ra, rb);
        end

        // Asynchronous reset in the middle of a MUL.
        apply_stimulus("pre_rst", `ADD, 16'd40, 16'd2);
        issue(`MUL, 16'd300, 16'd7);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_c", {16'b0, c}, 32'd0);
        check_output("midrst_ovalid", {31'b0, out_valid}, 32'd0);
        check_output("midrst_flags", {27'b0, overflow, comp_flag, div_zero, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) guard++;
        end
        check_output("midrst_spurious", guard, 32'd0);
        check_output("midrst_iready", {31'b0, in_ready}, 32'd1);
        apply_stimulus("post_rst", `ADD, 16'hFFFF, 16'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
